// File: rtl/poly_pkg.sv
// Shared types for the polynomial evaluator / inverse pair: FSM encoding,
// ALU operand selects and the control-to-datapath enable bundle.
package poly_pkg;

  localparam int POLY_WIDTH = 8;

  typedef enum logic [3:0] {
    S_LOAD_A      = 4'd0,
    S_LOAD_A_WAIT = 4'd1,
    S_LOAD_B      = 4'd2,
    S_LOAD_B_WAIT = 4'd3,
    S_LOAD_C      = 4'd4,
    S_LOAD_C_WAIT = 4'd5,
    S_LOAD_Y      = 4'd6,
    S_LOAD_Y_WAIT = 4'd7,
    S_INIT        = 4'd8,
    S_EVAL_0      = 4'd9,
    S_EVAL_1      = 4'd10,
    S_EVAL_2      = 4'd11,
    S_EVAL_3      = 4'd12,
    S_CMP         = 4'd13,
    S_DONE        = 4'd14
  } state_e;

  typedef enum logic {
    ALU_A_T = 1'b0,
    ALU_A_C = 1'b1
  } alu_asel_e;

  typedef enum logic [1:0] {
    ALU_B_X = 2'd0,
    ALU_B_B = 2'd1,
    ALU_B_A = 2'd2
  } alu_bsel_e;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_MUL = 1'b1
  } alu_op_e;

  typedef struct packed {
    logic      ld_a;
    logic      ld_b;
    logic      ld_c;
    logic      ld_y;
    logic      x_clr;
    logic      t_ld;
    logic      cmp_en;
    alu_asel_e asel;
    alu_bsel_e bsel;
    alu_op_e   op;
  } ctrl_t;

endpackage

// File: rtl/poly_inverse_control.sv
// Sequencer for the inverse search: press/release operand loading, then a
// five-state Horner evaluation loop per candidate x. All outputs are Moore.
module poly_inverse_control
  import poly_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  go,
  input  logic  t_eq_y,
  input  logic  x_max,
  output ctrl_t ctrl,
  output logic  done,
  output logic  busy
);

  state_e state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_LOAD_A;
    end else begin
      case (state)
        S_LOAD_A:      state <= go ? S_LOAD_A_WAIT : S_LOAD_A;
        S_LOAD_A_WAIT: state <= go ? S_LOAD_A_WAIT : S_LOAD_B;
        S_LOAD_B:      state <= go ? S_LOAD_B_WAIT : S_LOAD_B;
        S_LOAD_B_WAIT: state <= go ? S_LOAD_B_WAIT : S_LOAD_C;
        S_LOAD_C:      state <= go ? S_LOAD_C_WAIT : S_LOAD_C;
        S_LOAD_C_WAIT: state <= go ? S_LOAD_C_WAIT : S_LOAD_Y;
        S_LOAD_Y:      state <= go ? S_LOAD_Y_WAIT : S_LOAD_Y;
        S_LOAD_Y_WAIT: state <= go ? S_LOAD_Y_WAIT : S_INIT;
        S_INIT:        state <= S_EVAL_0;
        S_EVAL_0:      state <= S_EVAL_1;
        S_EVAL_1:      state <= S_EVAL_2;
        S_EVAL_2:      state <= S_EVAL_3;
        S_EVAL_3:      state <= S_CMP;
        S_CMP:         state <= (t_eq_y || x_max) ? S_DONE : S_EVAL_0;
        S_DONE:        state <= S_LOAD_A;
        default:       state <= S_LOAD_A;
      endcase
    end
  end

  // Horner steps: t = c*x, t+b, t*x, t+a
  always_comb begin
    ctrl = '0;
    ctrl.asel = ALU_A_T;
    ctrl.bsel = ALU_B_X;
    ctrl.op   = ALU_ADD;
    case (state)
      S_LOAD_A: ctrl.ld_a  = 1'b1;
      S_LOAD_B: ctrl.ld_b  = 1'b1;
      S_LOAD_C: ctrl.ld_c  = 1'b1;
      S_LOAD_Y: ctrl.ld_y  = 1'b1;
      S_INIT:   ctrl.x_clr = 1'b1;
      S_EVAL_0: begin
        ctrl.t_ld = 1'b1; ctrl.asel = ALU_A_C; ctrl.bsel = ALU_B_X; ctrl.op = ALU_MUL;
      end
      S_EVAL_1: begin
        ctrl.t_ld = 1'b1; ctrl.asel = ALU_A_T; ctrl.bsel = ALU_B_B; ctrl.op = ALU_ADD;
      end
      S_EVAL_2: begin
        ctrl.t_ld = 1'b1; ctrl.asel = ALU_A_T; ctrl.bsel = ALU_B_X; ctrl.op = ALU_MUL;
      end
      S_EVAL_3: begin
        ctrl.t_ld = 1'b1; ctrl.asel = ALU_A_T; ctrl.bsel = ALU_B_A; ctrl.op = ALU_ADD;
      end
      S_CMP:    ctrl.cmp_en = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    busy = (state >= S_INIT) && (state <= S_CMP);
    done = (state == S_DONE);
  end

endmodule

// File: rtl/poly_inverse_datapath.sv
// Operand/candidate registers, the shared add/multiply ALU and the compare.
// The CMP decision (record hit, record miss, or advance x) is made here.
module poly_inverse_datapath
  import poly_pkg::*;
#(
  parameter int WIDTH = POLY_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  ctrl_t            ctrl,
  output logic             t_eq_y,
  output logic             x_max,
  output logic [WIDTH-1:0] data_result,
  output logic             found
);

  logic [WIDTH-1:0] a, b, c, y, x, t;
  logic [WIDTH-1:0] op_a, op_b, alu_out;

  always_comb begin
    op_a = (ctrl.asel == ALU_A_C) ? c : t;
    case (ctrl.bsel)
      ALU_B_B: op_b = b;
      ALU_B_A: op_b = a;
      default: op_b = x;
    endcase
    alu_out = (ctrl.op == ALU_MUL) ? op_a * op_b : op_a + op_b;
  end

  assign t_eq_y = (t == y);
  assign x_max  = (x == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a <= '0; b <= '0; c <= '0; y <= '0; x <= '0; t <= '0;
      data_result <= '0;
      found       <= 1'b0;
    end else begin
      if (ctrl.ld_a)  a <= data_in;
      if (ctrl.ld_b)  b <= data_in;
      if (ctrl.ld_c)  c <= data_in;
      if (ctrl.ld_y)  y <= data_in;
      if (ctrl.x_clr) x <= '0;
      if (ctrl.t_ld)  t <= alu_out;
      if (ctrl.cmp_en) begin
        if (t_eq_y) begin
          data_result <= x;
          found       <= 1'b1;
        end else if (x_max) begin
          data_result <= '0;
          found       <= 1'b0;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/poly_inverse.sv
// Smallest-x solver for (C*x^2 + B*x + A) mod 2^WIDTH == Y; wiring only.
module poly_inverse
  import poly_pkg::*;
#(
  parameter int WIDTH = POLY_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_result,
  output logic             found,
  output logic             done,
  output logic             busy
);

  ctrl_t ctrl;
  logic  t_eq_y, x_max;

  poly_inverse_control u_ctrl (
    .clk    (clk),
    .resetn (resetn),
    .go     (go),
    .t_eq_y (t_eq_y),
    .x_max  (x_max),
    .ctrl   (ctrl),
    .done   (done),
    .busy   (busy)
  );

  poly_inverse_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .resetn      (resetn),
    .data_in     (data_in),
    .ctrl        (ctrl),
    .t_eq_y      (t_eq_y),
    .x_max       (x_max),
    .data_result (data_result),
    .found       (found)
  );

endmodule

// File: tb/tb_poly_inverse.sv
// Directed bench for poly_inverse: load/search scenarios with hand-computed
// results and done-cycle counts measured from the first INIT cycle.
module tb_poly_inverse;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         go = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_result;
  logic         found, done, busy;

  int checks = 0;
  int errors = 0;

  poly_inverse #(.WIDTH(W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .go          (go),
    .data_in     (data_in),
    .data_result (data_result),
    .found       (found),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at a negedge with the next LOAD state entered.
  task automatic press(input logic [W-1:0] v, input int hold);
    data_in = v;
    go = 1'b1;
    @(negedge clk);
    data_in = ~v;  // must not be captured while waiting for release
    for (int i = 1; i < hold; i++) @(negedge clk);
    go = 1'b0;
    @(negedge clk);
  endtask

  task automatic load4(input logic [W-1:0] va, vb, vc, vy, input int hold);
    press(va, hold);
    press(vb, hold);
    press(vc, hold);
    press(vy, hold);
  endtask

  // Starts at the negedge of cycle 0 (INIT). Optionally toggles go during search.
  task automatic run_check(input string name, input logic [W-1:0] exp_res,
                           input logic exp_found, input int exp_cyc, input bit toggle);
    int cyc = 0;
    int busy_bad = 0;
    while (done !== 1'b1 && cyc < 1400) begin
      if (busy !== 1'b1) busy_bad++;
      if (toggle) go = ~go;
      @(negedge clk);
      cyc++;
    end
    go = 1'b0;
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (data_result !== exp_res || found !== exp_found) begin
      errors++;
      $display("FAIL %s result: got %0d/%0b expected %0d/%0b", name, data_result, found, exp_res, exp_found);
    end
    checks++;
    if (busy_bad != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: %0d low cycles during search, busy at done %0b expected 0", name, busy_bad, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || data_result !== exp_res || found !== exp_found) begin
      errors++;
      $display("FAIL %s after_done: done=%0b busy=%0b res=%0d found=%0b expected 0 0 %0d %0b",
               name, done, busy, data_result, found, exp_res, exp_found);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (data_result !== '0 || found !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: res=%0d found=%0b done=%0b busy=%0b expected all 0", data_result, found, done, busy);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load4(8'd3, 8'd2, 8'd1, 8'd11, 1);
    run_check("quad_x2", 8'd2, 1'b1, 16, 1'b0);
    load4(8'd5, 8'd0, 8'd0, 8'd5, 1);
    run_check("const_x0", 8'd0, 1'b1, 6, 1'b0);
  endtask

  task automatic test_wrap();
    load4(8'd200, 8'd1, 8'd0, 8'd10, 1);
    run_check("add_wrap", 8'd66, 1'b1, 336, 1'b0);
  endtask

  task automatic test_no_solution();
    load4(8'd1, 8'd0, 8'd0, 8'd2, 1);
    run_check("no_sol", 8'd0, 1'b0, 1281, 1'b0);
  endtask

  task automatic test_go_held();
    // 4*x^2 + 0*x + 7 == 23 -> x=2 (16+7)
    load4(8'd7, 8'd0, 8'd4, 8'd23, 4);
    run_check("go_held", 8'd2, 1'b1, 16, 1'b1);
  endtask

  task automatic test_reset_mid();
    int quiet = 0;
    load4(8'd1, 8'd0, 8'd0, 8'd2, 1);
    repeat (100) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (data_result !== '0 || found !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: res=%0d found=%0b done=%0b busy=%0b expected all 0", data_result, found, done, busy);
    end
    resetn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet++;
    end
    checks++;
    if (quiet != 0) begin
      errors++;
      $display("FAIL reset_mid_idle: %0d cycles with done/busy high, expected 0", quiet);
    end
    load4(8'd3, 8'd2, 8'd1, 8'd11, 1);
    run_check("after_reset", 8'd2, 1'b1, 16, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_no_solution();
    test_go_held();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
